// File: rtl/apu_pkg.sv
// Shared APU types: fetch-sequencer states and the default tone-code width.
package apu_pkg;

  localparam int TONE_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CUR  = 3'd1,
    CAP_CUR = 3'd2,
    RD_LA   = 3'd3,
    CAP_LA  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/tick_divider.sv
// Note-rate divider: counts enabled clocks 0..DIV-1 and flags the wrap cycle.
module tick_divider #(
  parameter int CLK_HZ  = 12_288_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Combinational so the beat advance lands on the same edge as the wrap.
  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// N-channel note sequencer: loops a beat address over a pattern window, fetches the
// current and lookahead beat words over one read port, and overlays a timed one-shot.
module note_sequencer
  import apu_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int TONE_W   = TONE_W_DEF,
  parameter int ADDR_W   = 10,
  parameter int CLK_HZ   = 12_288_000,
  parameter int TICK_HZ  = 1,
  parameter int OS_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     restart,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  input  logic [ADDR_W-1:0]        lookahead_offset,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic [NUM_CH*TONE_W-1:0] mem_data,
  input  logic                     os_send,
  input  logic [NUM_CH*TONE_W-1:0] os_tones,
  output logic [NUM_CH*TONE_W-1:0] tones,
  output logic                     note_tick,
  output logic [NUM_CH*TONE_W-1:0] la_tones,
  output logic                     la_valid,
  input  logic                     la_ack,
  output logic [ADDR_W-1:0]        timestamp
);

  localparam int WORD_W = NUM_CH * TONE_W;
  localparam int OS_W   = $clog2(OS_TICKS + 1);

  fetch_state_t      state, state_nx;
  logic              started, restart_i, div_tick, adv, req_pend;
  logic [ADDR_W-1:0] beat_addr, mem_addr_q, la_addr;
  logic [WORD_W-1:0] cur, os_reg;
  logic [OS_W-1:0]   os_left;

  // The first cycle out of reset behaves exactly like an explicit restart.
  assign restart_i = restart || !started;
  assign adv       = div_tick && !restart_i;
  assign la_addr   = beat_addr + lookahead_offset;
  assign timestamp = beat_addr - start_addr;

  tick_divider #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick_divider (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .clear  (restart_i),
    .tick   (div_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started   <= 1'b0;
      beat_addr <= '0;
      note_tick <= 1'b0;
    end else begin
      started   <= 1'b1;
      note_tick <= adv;
      if (restart_i) begin
        beat_addr <= start_addr;
      end else if (adv) begin
        beat_addr <= (beat_addr == end_addr) ? start_addr : beat_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    mem_addr = mem_addr_q;
    case (state)
      IDLE:    if (adv || req_pend) state_nx = RD_CUR;
      RD_CUR:  begin
        mem_rd   = 1'b1;
        mem_addr = beat_addr;
        state_nx = CAP_CUR;
      end
      CAP_CUR: state_nx = RD_LA;
      RD_LA:   begin
        mem_rd   = 1'b1;
        mem_addr = la_addr;
        state_nx = CAP_LA;
      end
      CAP_LA:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (restart_i) state_nx = RD_CUR;
  end

  // la_valid/la_ack: la_valid rises when a non-zero lookahead word is captured and
  // stays up until la_ack is seen; a capture in the ack cycle wins, and a new capture
  // replaces an unacknowledged word without stalling the fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_pend   <= 1'b0;
      mem_addr_q <= '0;
      cur        <= '0;
      la_tones   <= '0;
      la_valid   <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr;
      if (restart_i) begin
        req_pend <= 1'b0;
      end else if (adv && state != IDLE) begin
        req_pend <= 1'b1;
      end else if (state == IDLE) begin
        req_pend <= 1'b0;
      end
      if (state == CAP_CUR && !restart_i) cur <= mem_data;
      if (restart_i) begin
        la_valid <= 1'b0;
      end else if (state == CAP_LA) begin
        la_tones <= mem_data;
        la_valid <= |mem_data;
      end else if (la_ack) begin
        la_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_reg  <= '0;
      os_left <= '0;
    end else if (os_send) begin
      os_reg  <= os_tones;
      os_left <= OS_W'(OS_TICKS);
    end else if (adv && os_left != '0) begin
      os_left <= os_left - 1'b1;
      if (os_left == OS_W'(1)) os_reg <= '0;
    end
  end

  always_comb begin
    tones = cur;
    for (int c = 0; c < NUM_CH; c++) begin
      if (os_reg[c*TONE_W +: TONE_W] != '0) tones[c*TONE_W +: TONE_W] = os_reg[c*TONE_W +: TONE_W];
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboarded bench for note_sequencer: beat-level model pushes one entry per fetch,
// a monitor pops on each fetch strobe and checks addresses, tones and lookahead.
module tb_note_sequencer;

  localparam int DIV      = 16;
  localparam int OS_TICKS = 2;

  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, restart = 1'b0;
  logic        os_send = 1'b0, la_ack = 1'b0;
  logic [9:0]  start_addr = '0, end_addr = '0, lookahead_offset = '0;
  logic [15:0] mem_data = '0, os_tones = '0;
  logic [9:0]  mem_addr, timestamp;
  logic        mem_rd, note_tick, la_valid;
  logic [15:0] tones, la_tones;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic        tick;
    logic        full;
    logic [9:0]  cur;
    logic [9:0]  ts;
    logic [9:0]  la_addr;
    logic [15:0] tones;
    logic [15:0] la;
    logic        lav;
    logic        lav_late;
    logic [15:0] tones_late;
  } exp_t;

  exp_t exp_q[$];

  // Beat-level reference state
  logic [9:0]  m_start, m_end, m_off, m_beat;
  logic [15:0] m_os;
  int          m_os_rem;

  note_sequencer #(
    .NUM_CH(4), .TONE_W(4), .ADDR_W(10), .CLK_HZ(DIV), .TICK_HZ(1), .OS_TICKS(OS_TICKS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
    .start_addr(start_addr), .end_addr(end_addr), .lookahead_offset(lookahead_offset),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .os_send(os_send), .os_tones(os_tones), .tones(tones), .note_tick(note_tick),
    .la_tones(la_tones), .la_valid(la_valid), .la_ack(la_ack), .timestamp(timestamp)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_data <= {4{mem_addr[3:0]}};

  // ---------------- helpers ----------------
  function automatic logic [15:0] pat(input logic [9:0] a);
    return {4{a[3:0]}};
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] os, input logic [15:0] base);
    logic [15:0] r;
    for (int c = 0; c < 4; c++) r[c*4 +: 4] = (os[c*4 +: 4] != 4'h0) ? os[c*4 +: 4] : base[c*4 +: 4];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_entry(input logic is_tick, input logic full, input int os_at,
                            input logic [15:0] os_w, input int ack_at);
    exp_t e;
    e.cyc      = cyc;
    e.tick     = is_tick;
    e.full     = full;
    e.cur      = m_beat;
    e.ts       = m_beat - m_start;
    e.tones    = merge(m_os, pat(m_beat));
    e.la_addr  = m_beat + m_off;
    e.la       = pat(e.la_addr);
    e.lav      = (e.la != 16'h0);
    e.lav_late = (ack_at >= 6) ? 1'b0 : e.lav;
    if (os_at >= 0) begin
      m_os     = os_w;
      m_os_rem = OS_TICKS;
    end
    e.tones_late = merge(m_os, pat(m_beat));
    exp_q.push_back(e);
  endtask

  task automatic set_window(input logic [9:0] ns, input logic [9:0] ne, input logic [9:0] no);
    start_addr = ns; end_addr = ne; lookahead_offset = no;
    m_start = ns; m_end = ne; m_off = no; m_beat = ns;
  endtask

  // Runs one beat from its fetch cycle to the next fetch cycle.
  task automatic finish_beat(input int os_at, input logic [15:0] os_w, input int ack_at,
                             input int pause_at, input int pause_len, input logic rs,
                             input logic [9:0] ns, input logic [9:0] ne, input logic [9:0] no);
    int off = 0;
    int en_cnt = 0;
    while (en_cnt < DIV) begin
      enable   = !(pause_len > 0 && off >= pause_at && off < pause_at + pause_len);
      os_send  = (off == os_at);
      os_tones = os_w;
      la_ack   = (off == ack_at);
      restart  = rs && enable && (en_cnt == DIV - 1);
      if (restart) begin
        start_addr = ns; end_addr = ne; lookahead_offset = no;
      end
      @(posedge clk); #1;
      if (enable) en_cnt++;
      off++;
    end
    enable = 1'b1; os_send = 1'b0; la_ack = 1'b0; restart = 1'b0;
    if (rs) begin
      set_window(ns, ne, no);
    end else begin
      m_beat = (m_beat == m_end) ? m_start : m_beat + 10'd1;
      if (m_os_rem > 0) begin
        m_os_rem--;
        if (m_os_rem == 0) m_os = '0;
      end
    end
  endtask

  task automatic do_beat(input logic is_tick, input int os_at, input logic [15:0] os_w,
                         input int ack_at, input int pause_at, input int pause_len,
                         input logic rs, input logic [9:0] ns, input logic [9:0] ne,
                         input logic [9:0] no);
    push_entry(is_tick, 1'b1, os_at, os_w, ack_at);
    finish_beat(os_at, os_w, ack_at, pause_at, pause_len, rs, ns, ne, no);
  endtask

  // Restart one cycle into a fetch: the fetch is abandoned and restarts at ns.
  task automatic abort_beat(input logic is_tick, input logic [9:0] ns, input logic [9:0] ne,
                            input logic [9:0] no);
    push_entry(is_tick, 1'b0, -1, 16'h0, -1);
    @(posedge clk); #1;
    restart = 1'b1;
    set_window(ns, ne, no);
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic rand_beat(input logic is_tick, output logic next_tick);
    int kind, os_at, ack_sel, ack_at, pause_len, pause_at;
    logic [15:0] os_w;
    logic [9:0] ns, ne, no;
    kind      = $urandom_range(0, 9);
    os_at     = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 9) : -1;
    os_w      = 16'($urandom);
    ack_sel   = $urandom_range(0, 4);
    ack_at    = (ack_sel == 0) ? -1 : (ack_sel == 1) ? 3 : 4 + ack_sel;
    pause_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
    pause_at  = $urandom_range(11, 13);
    ns        = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1020, 1023)) : 10'($urandom);
    ne        = ns + 10'($urandom_range(0, 5));
    no        = ($urandom_range(0, 4) == 0) ? 10'($urandom) : 10'($urandom_range(0, 40));
    if (kind == 0) begin
      abort_beat(is_tick, ns, ne, no);
      next_tick = 1'b0;
    end else begin
      do_beat(is_tick, os_at, os_w, ack_at, pause_at, pause_len, kind == 1, ns, ne, no);
      next_tick = (kind != 1);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_read at cycle %0d: mem_addr %0h, no fetch expected", cyc, mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("fetch_cycle", 32'(cyc), 32'(e.cyc));
          check("cur_addr", 32'(mem_addr), 32'(e.cur));
          check("note_tick", 32'(note_tick), 32'(e.tick));
          check("timestamp", 32'(timestamp), 32'(e.ts));
          @(negedge clk);
          check("rd_gap", 32'(mem_rd), 32'd0);
          check("addr_hold", 32'(mem_addr), 32'(e.cur));
          check("tick_width", 32'(note_tick), 32'd0);
          if (e.full) begin
            @(negedge clk);
            check("tones", 32'(tones), 32'(e.tones));
            check("la_rd", 32'(mem_rd), 32'd1);
            check("la_addr", 32'(mem_addr), 32'(e.la_addr));
            repeat (2) @(negedge clk);
            check("la_tones", 32'(la_tones), 32'(e.la));
            check("la_valid", 32'(la_valid), 32'(e.lav));
            repeat (6) @(negedge clk);
            check("la_valid_late", 32'(la_valid), 32'(e.lav_late));
            check("tones_late", 32'(tones), 32'(e.tones_late));
          end
        end
      end else begin
        check("idle_note_tick", 32'(note_tick), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic nt;
    start_addr = 10'd5; end_addr = 10'd7; lookahead_offset = 10'd2; enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tones", 32'(tones), 32'd0);
    check("rst_la_tones", 32'(la_tones), 32'd0);
    check("rst_la_valid", 32'(la_valid), 32'd0);
    check("rst_note_tick", 32'(note_tick), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_start = 10'd5; m_end = 10'd7; m_off = 10'd2; m_beat = 10'd5; m_os = '0; m_os_rem = 0;
    @(posedge clk); #1;
    // Directed: loop 5..7, lookahead 9, ack collision, one-shot, long pause, restart on tick
    do_beat(1'b0, -1, 16'h0,   -1, 0, 0,  1'b0, 10'd0, 10'd0, 10'd0);
    do_beat(1'b1, -1, 16'h0,    7, 0, 0,  1'b0, 10'd0, 10'd0, 10'd0);
    do_beat(1'b1, -1, 16'h0,    3, 0, 0,  1'b0, 10'd0, 10'd0, 10'd0);
    do_beat(1'b1,  6, 16'hA000, -1, 0, 0, 1'b0, 10'd0, 10'd0, 10'd0);
    do_beat(1'b1, -1, 16'h0,   -1, 0, 0,  1'b0, 10'd0, 10'd0, 10'd0);
    do_beat(1'b1, -1, 16'h0,   -1, 12, 40, 1'b0, 10'd0, 10'd0, 10'd0);
    do_beat(1'b1, -1, 16'h0,   -1, 0, 0,  1'b1, 10'd14, 10'd16, 10'd2);
    do_beat(1'b0, -1, 16'h0,   -1, 0, 0,  1'b0, 10'd0, 10'd0, 10'd0);
    do_beat(1'b1, -1, 16'h0,    8, 0, 0,  1'b0, 10'd0, 10'd0, 10'd0);
    nt = 1'b1;
    for (int i = 0; i < 45; i++) rand_beat(nt, nt);
    // Final fetch, then hold the divider so no further beats start.
    push_entry(nt, 1'b1, -1, 16'h0, -1);
    enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
